// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter: round-robin arbiter that sequences two requesters' register
// read/write transactions onto an I2C master engine's command/response port.
module i2c_txn_arbiter #(
  parameter logic [6:0] SADR  = 7'b1010011,
  parameter int         LEN_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_val,
  output logic [1:0]       req_rdy,
  input  logic [1:0]       req_rw,
  input  logic [7:0]       req_reg0,
  input  logic [7:0]       req_reg1,
  input  logic [LEN_W-1:0] req_len0,
  input  logic [LEN_W-1:0] req_len1,
  input  logic [7:0]       req_wdata0,
  input  logic [7:0]       req_wdata1,
  output logic             rd_val,
  output logic [7:0]       rd_data,
  output logic             rd_src,
  output logic             done,
  output logic             busy,
  output logic [6:0]       cmd_addr,
  output logic [2:0]       cmd_op,
  output logic             cmd_fun,
  output logic [7:0]       cmd_wdata,
  output logic             cmd_val,
  input  logic             cmd_rdy,
  input  logic             rsp_val,
  output logic             rsp_rdy,
  input  logic [7:0]       rsp_data
);
  localparam logic [2:0] OP_INITIALIZE = 3'd0;
  localparam logic [2:0] OP_START      = 3'd1;
  localparam logic [2:0] OP_WRITE      = 3'd2;
  localparam logic [2:0] OP_READ       = 3'd3;
  localparam logic [2:0] OP_STOP       = 3'd4;
  typedef enum logic [3:0] {
    INIT_I, INIT_W, IDLE, STA_I, STA_W, REG_I, REG_W, DAT_I, DAT_W,
    RST_I, RST_W, RD_I, RD_W, STP_I, STP_W
  } state_t;
  state_t state, nxt;
  logic pri, gnt, gnt_any, issue, waits, cmd_hs, rsp_hs, last_rd, rw_q;
  logic [7:0] reg_q, wdata_q;
  logic [LEN_W-1:0] len_q, cnt;
  always_comb begin
    issue     = state inside {INIT_I, STA_I, REG_I, DAT_I, RST_I, RD_I, STP_I};
    waits     = state inside {INIT_W, STA_W, REG_W, DAT_W, RST_W, RD_W, STP_W};
    gnt       = req_val[pri] ? pri : ~pri;
    gnt_any   = !reset && state == IDLE && |req_val;
    req_rdy   = gnt_any ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    cmd_val   = !reset && issue;
    rsp_rdy   = !reset && waits;
    cmd_hs    = cmd_val && cmd_rdy;
    rsp_hs    = rsp_val && rsp_rdy;
    last_rd   = cnt == len_q;
    busy      = reset || state != IDLE;
    cmd_addr  = SADR;
    cmd_op    = state inside {STA_I, RST_I} ? OP_START :
                state inside {REG_I, DAT_I} ? OP_WRITE :
                state == RD_I ? OP_READ :
                state == STP_I ? OP_STOP : OP_INITIALIZE;
    cmd_fun   = state == STA_I || state == DAT_I || (state == RD_I && last_rd);
    cmd_wdata = state == REG_I ? reg_q : state == DAT_I ? wdata_q : 8'h00;
    nxt       = state;
    case (state)
      INIT_I:  nxt = cmd_hs ? INIT_W : INIT_I;
      INIT_W:  nxt = rsp_hs ? IDLE : INIT_W;
      IDLE:    nxt = gnt_any ? STA_I : IDLE;
      STA_I:   nxt = cmd_hs ? STA_W : STA_I;
      STA_W:   nxt = rsp_hs ? REG_I : STA_W;
      REG_I:   nxt = cmd_hs ? REG_W : REG_I;
      REG_W:   nxt = rsp_hs ? (rw_q ? RST_I : DAT_I) : REG_W;
      DAT_I:   nxt = cmd_hs ? DAT_W : DAT_I;
      DAT_W:   nxt = rsp_hs ? IDLE : DAT_W;
      RST_I:   nxt = cmd_hs ? RST_W : RST_I;
      RST_W:   nxt = rsp_hs ? RD_I : RST_W;
      RD_I:    nxt = cmd_hs ? RD_W : RD_I;
      RD_W:    nxt = rsp_hs ? (last_rd ? STP_I : RD_I) : RD_W;
      STP_I:   nxt = cmd_hs ? STP_W : STP_I;
      STP_W:   nxt = rsp_hs ? IDLE : STP_W;
      default: nxt = INIT_I;
    endcase
  end
  always_ff @(posedge clk) state <= reset ? INIT_I : nxt;
  always_ff @(posedge clk) begin
    if (reset) begin
      pri     <= 1'b0;
      rd_src  <= 1'b0;
      cnt     <= '0;
      rd_val  <= 1'b0;
      done    <= 1'b0;
      rd_data <= 8'h00;
    end else begin
      rd_val <= state == RD_W && rsp_hs;
      done   <= rsp_hs && (state == DAT_W || state == STP_W);
      if (state == RD_W && rsp_hs) rd_data <= rsp_data;
      if (gnt_any) begin
        pri    <= ~gnt;
        rd_src <= gnt;
        cnt    <= '0;
      end else if (state == RD_W && rsp_hs && !last_rd) begin
        cnt <= cnt + LEN_W'(1);
      end
    end
  end
  // request fields are captured once at grant so later req_* changes cannot disturb the transaction
  always_ff @(posedge clk) begin
    if (gnt_any) begin
      rw_q    <= req_rw[gnt];
      reg_q   <= gnt ? req_reg1 : req_reg0;
      len_q   <= gnt ? req_len1 : req_len0;
      wdata_q <= gnt ? req_wdata1 : req_wdata0;
    end
  end
endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// tb_i2c_txn_arbiter: scoreboard bench with a transaction-level reference model,
// randomized requesters and an engine model with configurable command back-pressure.
module tb_i2c_txn_arbiter;
  localparam int LEN_W = 3;
  localparam logic [6:0] SADR = 7'b1010011;
  localparam logic [2:0] OP_INIT = 3'd0, OP_START = 3'd1, OP_WRITE = 3'd2, OP_READ = 3'd3, OP_STOP = 3'd4;
  typedef struct packed {logic [2:0] op; logic fun; logic [7:0] wd;} cmd_t;
  logic clk = 0, reset = 1;
  logic [1:0] req_val = 2'b00, req_rw = 2'b00, req_rdy;
  logic [7:0] r_reg [2] = '{8'h00, 8'h00};
  logic [7:0] r_wd [2] = '{8'h00, 8'h00};
  logic [LEN_W-1:0] r_len [2] = '{'0, '0};
  logic rd_val, rd_src, done, busy, cmd_fun, cmd_val, rsp_rdy;
  logic [7:0] rd_data, cmd_wdata;
  logic [6:0] cmd_addr;
  logic [2:0] cmd_op;
  logic cmd_rdy = 1, rsp_val = 0;
  logic [7:0] rsp_data = 8'h00;
  int checks = 0, errors = 0;
  cmd_t exp_cmd[$];
  logic [8:0] exp_rd[$];
  logic exp_done[$];
  logic [7:0] fix_q[$];
  logic glog[$];
  int mode = 0, rdy_mode = 0, rdy_fix = 0, n_reads = 0, init_cnt = 0, ntx = 0;
  logic pri_m = 0, cur_src = 0;
  int dir_go = 0, dir_seen = 0;
  logic dir_i = 0, dir_rw = 0;
  logic [7:0] dir_reg = 0, dir_wd = 0;
  logic [LEN_W-1:0] dir_len = 0;

  i2c_txn_arbiter #(.SADR(SADR), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .req_val(req_val), .req_rdy(req_rdy), .req_rw(req_rw),
    .req_reg0(r_reg[0]), .req_reg1(r_reg[1]), .req_len0(r_len[0]), .req_len1(r_len[1]),
    .req_wdata0(r_wd[0]), .req_wdata1(r_wd[1]), .rd_val(rd_val), .rd_data(rd_data),
    .rd_src(rd_src), .done(done), .busy(busy), .cmd_addr(cmd_addr), .cmd_op(cmd_op),
    .cmd_fun(cmd_fun), .cmd_wdata(cmd_wdata), .cmd_val(cmd_val), .cmd_rdy(cmd_rdy),
    .rsp_val(rsp_val), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic cmd_t mk(input logic [2:0] op, input logic fun, input logic [7:0] wd);
    cmd_t c;
    c.op = op;
    c.fun = fun;
    c.wd = wd;
    return c;
  endfunction

  // reference model: the full command list a granted request must produce
  task automatic push_txn(input logic i);
    exp_cmd.push_back(mk(OP_START, 1'b1, 8'h00));
    exp_cmd.push_back(mk(OP_WRITE, 1'b0, r_reg[i]));
    if (req_rw[i]) begin
      exp_cmd.push_back(mk(OP_START, 1'b0, 8'h00));
      for (int k = 0; k <= int'(r_len[i]); k++) exp_cmd.push_back(mk(OP_READ, k == int'(r_len[i]), 8'h00));
      exp_cmd.push_back(mk(OP_STOP, 1'b0, 8'h00));
    end else begin
      exp_cmd.push_back(mk(OP_WRITE, 1'b1, r_wd[i]));
    end
    exp_done.push_back(i);
  endtask

  task automatic new_fields(input int i);
    req_rw[i] = 1'($urandom);
    r_reg[i] = 8'($urandom);
    r_len[i] = LEN_W'($urandom);
    r_wd[i] = 8'($urandom);
  endtask

  function automatic int pick();
    return rdy_mode == 0 ? 0 : rdy_mode == 1 ? rdy_fix : int'($urandom_range(0, 3));
  endfunction

  // requester driver and arbitration model
  always begin : drv
    logic [1:0] g;
    logic e;
    @(negedge clk);
    g = reset ? 2'b00 : req_rdy;
    if (reset) pri_m = 1'b0;
    else if (g != 2'b00) begin
      e = req_val[pri_m] ? pri_m : ~pri_m;
      chk("grant", 32'(g), 32'(e ? 2'b10 : 2'b01));
      push_txn(e);
      pri_m = ~e;
      cur_src = e;
      glog.push_back(e);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (g[i]) begin
        if (mode == 1) new_fields(i);
        else if (mode == 2) begin req_val[i] = 1'($urandom); new_fields(i); end
        else req_val[i] = 1'b0;
      end else if (mode == 2 && $urandom_range(0, 7) == 0) begin
        req_val[i] = ~req_val[i];
        new_fields(i);
      end else if (mode == 1 && !req_val[i]) begin
        new_fields(i);
        req_val[i] = 1'b1;
      end
    end
    if (dir_go != dir_seen) begin
      dir_seen = dir_go;
      req_rw[dir_i] = dir_rw;
      r_reg[dir_i] = dir_reg;
      r_len[dir_i] = dir_len;
      r_wd[dir_i] = dir_wd;
      req_val[dir_i] = 1'b1;
    end
  end

  // engine model: each command answered two cycles after acceptance
  always begin : eng
    logic cv, cr, hr;
    logic [2:0] op;
    static logic pend = 0;
    static int lat = 0, wcnt = 0, dly = 0;
    static logic [2:0] pop_op = 0;
    @(negedge clk);
    cv = cmd_val;
    cr = cmd_rdy;
    hr = rsp_val && rsp_rdy;
    op = cmd_op;
    @(posedge clk);
    #1;
    if (reset) begin
      pend = 0;
      rsp_val = 0;
      wcnt = 0;
      dly = pick();
      cmd_rdy = dly == 0;
    end else begin
      if (hr) rsp_val = 0;
      if (pend) begin
        lat--;
        if (lat == 0) begin
          pend = 0;
          rsp_val = 1;
          rsp_data = 8'($urandom);
          if (pop_op == OP_READ) begin
            if (fix_q.size() > 0) rsp_data = fix_q.pop_front();
            exp_rd.push_back({cur_src, rsp_data});
          end
        end
      end
      if (cv && cr) begin
        pend = 1;
        lat = 2;
        pop_op = op;
        if (op == OP_READ) n_reads++;
      end
      if (!cv) begin
        wcnt = 0;
        dly = pick();
        cmd_rdy = dly == 0;
      end else if (!cr) begin
        wcnt++;
        cmd_rdy = wcnt >= dly;
      end
    end
  end

  // monitor: pops expectations whenever the DUT presents a command, read byte or done
  always begin : mon
    static logic prev_wait = 0;
    static cmd_t prev_c = '0;
    cmd_t e;
    logic [8:0] r;
    @(negedge clk);
    if (reset) begin
      exp_cmd.delete();
      exp_rd.delete();
      exp_done.delete();
      exp_cmd.push_back(mk(OP_INIT, 1'b0, 8'h00));
      prev_wait = 0;
    end else begin
      if (prev_wait) chk("cmd_stable", 32'({cmd_val, cmd_op, cmd_fun, cmd_wdata}), 32'({1'b1, prev_c}));
      if (cmd_val && cmd_rdy) begin
        chk("cmd_expected", 32'(exp_cmd.size() > 0), 32'd1);
        if (exp_cmd.size() > 0) begin
          e = exp_cmd.pop_front();
          chk("cmd_op", 32'(cmd_op), 32'(e.op));
          chk("cmd_fun", 32'(cmd_fun), 32'(e.fun));
          if (e.op == OP_WRITE) chk("cmd_wdata", 32'(cmd_wdata), 32'(e.wd));
        end
        chk("cmd_addr", 32'(cmd_addr), 32'(SADR));
        if (cmd_op == OP_INIT) init_cnt++;
      end
      prev_wait = cmd_val && !cmd_rdy;
      prev_c = {cmd_op, cmd_fun, cmd_wdata};
      if (rsp_rdy) chk("rsp_rdy_excl", 32'(cmd_val), 32'd0);
      if (req_rdy != 2'b00) begin
        chk("rdy_onehot", 32'(req_rdy != 2'b11), 32'd1);
        chk("grant_not_busy", 32'(busy), 32'd0);
      end
      if (rd_val) begin
        chk("rd_expected", 32'(exp_rd.size() > 0), 32'd1);
        if (exp_rd.size() > 0) begin
          r = exp_rd.pop_front();
          chk("rd_data", 32'(rd_data), 32'(r[7:0]));
          chk("rd_src", 32'(rd_src), 32'(r[8]));
        end
      end
      if (done) begin
        ntx++;
        chk("done_expected", 32'(exp_done.size() > 0), 32'd1);
        if (exp_done.size() > 0) chk("done_src", 32'(rd_src), 32'(exp_done.pop_front()));
      end
    end
  end

  task automatic issue(input logic i, input logic rw, input logic [7:0] rg, input logic [LEN_W-1:0] ln, input logic [7:0] wd);
    dir_i = i;
    dir_rw = rw;
    dir_reg = rg;
    dir_len = ln;
    dir_wd = wd;
    dir_go++;
  endtask

  task automatic wait_idle(input string nm, input int max);
    checks++;
    for (int c = 0; c < max; c++) begin
      @(negedge clk);
      if (!busy && req_val == 2'b00 && dir_go == dir_seen && exp_cmd.size() == 0 &&
          exp_done.size() == 0 && exp_rd.size() == 0) return;
    end
    errors++;
    $display("FAIL %s: not idle after %0d cycles (busy=%0b cmds_left=%0d) expected idle", nm, max, busy, exp_cmd.size());
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, r0, i0, t0;
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_cmd_val", 32'(cmd_val), 32'd0);
    chk("rst_rsp_rdy", 32'(rsp_rdy), 32'd0);
    chk("rst_req_rdy", 32'(req_rdy), 32'd0);
    chk("rst_rd_val", 32'(rd_val), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(posedge clk);
    #2 reset = 0;
    wait_idle("init", 60);
    chk("init_count", 32'(init_cnt), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    repeat (5) begin
      @(negedge clk);
      chk("idle_no_rdy", 32'(req_rdy), 32'd0);
    end
    issue(1'b0, 1'b0, 8'h10, '0, 8'hA5);
    wait_idle("write0", 100);
    chk("write0_done", 32'(ntx), 32'd1);
    fix_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    issue(1'b1, 1'b1, 8'h00, LEN_W'(3), 8'h00);
    wait_idle("read1", 200);
    chk("read1_done", 32'(ntx), 32'd2);
    chk("read1_bytes_used", 32'(fix_q.size()), 32'd0);
    s = glog.size();
    mode = 1;
    for (int c = 0; c < 400 && glog.size() < s + 4; c++) @(negedge clk);
    mode = 0;
    wait_idle("rr", 400);
    chk("rr_grants", 32'(glog.size() >= s + 4), 32'd1);
    for (int k = 0; k < 4 && s + k < glog.size(); k++) chk("rr_order", 32'(glog[s+k]), 32'(k % 2));
    rdy_mode = 1;
    rdy_fix = 5;
    r0 = n_reads;
    issue(1'b0, 1'b1, 8'h5A, '0, 8'h00);
    wait_idle("len0", 400);
    chk("len0_reads", 32'(n_reads - r0), 32'd1);
    rdy_mode = 2;
    mode = 2;
    repeat (800) @(posedge clk);
    mode = 0;
    wait_idle("random", 3000);
    rdy_mode = 0;
    r0 = n_reads;
    i0 = init_cnt;
    t0 = ntx;
    issue(1'b1, 1'b1, 8'h33, LEN_W'(7), 8'h00);
    for (int c = 0; c < 200 && n_reads < r0 + 3; c++) @(posedge clk);
    chk("third_read_reached", 32'(n_reads >= r0 + 3), 32'd1);
    @(posedge clk);
    #2 reset = 1;
    repeat (2) @(posedge clk);
    #2 reset = 0;
    wait_idle("post_reset", 100);
    chk("reinit_count", 32'(init_cnt - i0), 32'd1);
    chk("no_done_on_abort", 32'(ntx), 32'(t0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2c_txn_arbiter.md
I2C_TXN_ARBITER -- requirements
Module: i2c_txn_arbiter

Interface
REQ-001 SHALL have parameter SADR, default 7'b1010011, the 7-bit I2C slave address driven on cmd_addr.
REQ-002 SHALL have parameter LEN_W, default 3; a request length field value n means n+1 bytes.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 req_val[1:0]  input  2  per-requester transaction request valid.
REQ-006 req_rdy[1:0]  output  2  per-requester accept; one-hot or zero.
REQ-007 req_rw[1:0]  input  2  per-requester: 1 = read, 0 = write.
REQ-008 req_reg0/req_reg1  input  8 each  device register (word) address.
REQ-009 req_len0/req_len1  input  LEN_W each  read byte count minus 1; ignored for writes.
REQ-010 req_wdata0/req_wdata1  input  8 each  write data byte.
REQ-011 rd_val  output  1  one-cycle pulse: read byte available.
REQ-012 rd_data  output  8  read byte, valid with rd_val.
REQ-013 rd_src  output  1  requester index owning rd_data and done.
REQ-014 done  output  1  one-cycle pulse at transaction completion.
REQ-015 busy  output  1  high from reset release until INIT completes, and while a transaction is in progress.
REQ-016 cmd_addr  output  7  always SADR.
REQ-017 cmd_op  output  3  engine operation (OP_INITIALIZE/OP_START/OP_WRITE/OP_READ/OP_STOP, from i2c_master_defines).
REQ-018 cmd_fun  output  1  engine function bit: START 1=write/0=read; WRITE 1=with stop; READ 1=NACK.
REQ-019 cmd_wdata  output  8  engine write byte.
REQ-020 cmd_val / cmd_rdy  output / input  1  command handshake; transfer when both high.
REQ-021 rsp_val / rsp_rdy / rsp_data  input / output / input  1/1/8  response handshake and read byte.

Function
REQ-022 Every command phase SHALL be split into an ISSUE state (cmd_val=1, rsp_rdy=0) and a WAIT state (cmd_val=0, rsp_rdy=1); ISSUE->WAIT on cmd_val&cmd_rdy; WAIT->next on rsp_val&rsp_rdy.
REQ-023 cmd_op/cmd_fun/cmd_wdata SHALL be stable for the whole ISSUE state.
REQ-024 After reset, the FSM SHALL issue one OP_INITIALIZE (fun=0) before accepting any request; req_rdy=0 until its response.
REQ-025 In IDLE, arbitration SHALL be round-robin: priority goes to the requester not granted last; after reset requester 0 has priority.
REQ-026 Grant SHALL be a one-cycle req_rdy pulse in IDLE; the granted requester's rw, reg, len, wdata SHALL be latched on that cycle, and the grant held until done.
REQ-027 Write sequence: START(fun=1), WRITE(reg, fun=0), WRITE(wdata, fun=1), then done.
REQ-028 Read sequence: START(fun=1), WRITE(reg, fun=0), START(fun=0), READ x (len+1), STOP(fun=0), then done.
REQ-029 In read, READ cmd_fun SHALL be 0 except for the final byte (byte index == len), where it SHALL be 1.
REQ-030 Each READ response handshake SHALL produce rd_val=1 with rd_data=rsp_data, registered, one cycle after the handshake.
REQ-031 done SHALL pulse the cycle after the final response handshake (write: second WRITE; read: STOP); FSM SHALL be in IDLE that same cycle.
REQ-032 len=0 SHALL read exactly one byte with NACK; len=2^LEN_W-1 SHALL read 2^LEN_W bytes; the byte counter SHALL not wrap.
REQ-033 Requests SHALL never be accepted while busy; req_val changes during a transaction SHALL not affect it.
REQ-034 A response arriving while in an ISSUE state SHALL be ignored (rsp_rdy=0).

Reset
REQ-035 On reset: FSM->INIT_ISSUE, req_rdy=0, rd_val=0, done=0, busy=1, cmd_val=0 in the reset cycle, rsp_rdy=0, byte counter=0, round-robin pointer favours requester 0.
REQ-036 Reset mid-transaction SHALL abandon it without STOP and restart at OP_INITIALIZE; no done pulse.

Verification
REQ-037 Reset, engine model acks every command after 2 cycles -> exactly one OP_INITIALIZE, then busy=0 and req_rdy stays 0 with no requests.
REQ-038 Requester 0 write reg=8'h10 data=8'hA5 -> commands START/1, WRITE 8'h10/0, WRITE 8'hA5/1; done=1, rd_src=0.
REQ-039 Requester 1 read reg=8'h00 len=3, model returns 8'h11,22,33,44 -> START/1, WRITE 00/0, START/0, READ fun 0,0,0,1, STOP; four rd_val pulses in order, rd_src=1.
REQ-040 Both req_val high continuously after reset -> grants alternate 0,1,0,1; never both req_rdy high.
REQ-041 Read with len=0 and cmd_rdy held low 5 cycles per command -> single READ with fun=1, cmd_val held stable until accepted.
REQ-042 Assert reset during third READ of a len=7 read -> no done, next command is OP_INITIALIZE.
